// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder
//
// Purpose:
//   Target side of the data-bus handshake. The responder accepts one request
//   at a time and serves it from an internal SRAM that is 64 bits wide. It
//   answers with a single-cycle data_ok pulse LATENCY cycles after accept.
//   The responder acts as a test data memory that has a fixed, predictable
//   latency.
//
// Ports:
//   i_clk    - clock; all state changes on the rising edge
//   i_reset  - synchronous, active-high reset
//   i_dreq   - request: valid, addr, size, strobe, data (strobe == 0 is a read)
//   o_dresp  - response: addr_ok (accept), data_ok (one-cycle pulse), data
//   o_busy   - high while a transaction is outstanding

package common;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

module dbus_sram_responder
    import common::*;
#(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LATENCY   = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  dbus_req_t  i_dreq,
    output dbus_resp_t o_dresp,
    output logic       o_busy
);

    localparam int unsigned Depth   = 1 << ADDR_BITS;
    localparam logic [3:0]  LatLoad = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_cnt;
    logic [3:0]           w_cnt_next;
    logic [63:0]          r_mem [Depth];
    logic [63:0]          r_rdata;
    logic                 r_is_read;
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_accept;
    logic                 w_unused_bits;

    // addr[2:0] and size are not used: a request always returns the full aligned word. The upper
    // address bits are also dropped, so addresses wrap at the SRAM size.
    assign w_idx    = i_dreq.addr[ADDR_BITS+2:3];
    assign w_accept = (r_state == StIdle) && i_dreq.valid && !i_reset;

    assign w_unused_bits = ^{i_dreq.size, i_dreq.addr[63:ADDR_BITS+3], i_dreq.addr[2:0]};

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (i_dreq.valid) begin
                    w_cnt_next   = LatLoad;
                    w_state_next = (LATENCY == 1) ? StDone : StWait;
                end
            end
            StWait: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Read data is captured at accept. The returned word therefore reflects every write that
    // committed before this request, and nothing the initiator does afterwards can change it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdata   <= 64'd0;
            r_is_read <= 1'b0;
        end else if (w_accept) begin
            r_rdata   <= r_mem[w_idx];
            r_is_read <= (i_dreq.strobe == 8'd0);
        end
    end

    // Writes commit on the accept edge. Reset does not undo a write that has already committed.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            for (int i = 0; i < 8; i++) begin
                if (i_dreq.strobe[i]) begin
                    r_mem[w_idx][8*i +: 8] <= i_dreq.data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        o_dresp         = '0;
        o_dresp.addr_ok = (r_state == StIdle) && i_dreq.valid && !i_reset;
        o_dresp.data_ok = (r_state == StDone);
        o_dresp.data    = ((r_state == StDone) && r_is_read) ? r_rdata : 64'd0;
        o_busy          = (r_state != StIdle);
    end

endmodule
